opb_status_bank: RTL

//  Multi-channel Simulink-to-PPC status register bank on the OPB bus: C_NUM_CH user status words, each with its own accumulation mode.

---
 rtl/opb_status_bank_pkg.sv | 40 ++++
 rtl/opb_status_bank_status_accum.sv | 53 +++++
 rtl/opb_status_bank.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/opb_status_bank_pkg.sv
// ============================================================================
// Module      : opb_status_bank_pkg
// Description : Shared mode codes, register offsets and ID constant for the
//               OPB multi-channel status register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package opb_status_bank_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'd0,
        MODE_STICKY = 2'd1,
        MODE_MAX    = 2'd2,
        MODE_COUNT  = 2'd3
    } ch_mode_e;

    localparam logic [31:0] c_off_id         = 32'h0000_0000;
    localparam logic [31:0] c_off_ctrl       = 32'h0000_0004;
    localparam logic [31:0] c_off_clear_mask = 32'h0000_0008;
    localparam logic [31:0] c_off_snap_count = 32'h0000_000C;
    localparam logic [31:0] c_off_ch_base    = 32'h0000_0010;

    localparam int c_ctrl_snap_bit      = 0;
    localparam int c_ctrl_clear_all_bit = 1;

    localparam logic [7:0] c_id_tag = 8'hB5;
    localparam logic [7:0] c_id_ver = 8'h02;

    function automatic logic [31:0] id_word(input int num_ch, input int status_w);
        return {c_id_tag, c_id_ver, 8'(num_ch), 8'(status_w)};
    endfunction

    function automatic logic [31:0] ch_offset(input int k);
        return c_off_ch_base + 32'(4 * k);
    endfunction

endpackage

`default_nettype wire

// File: rtl/opb_status_bank_status_accum.sv
// ============================================================================
// Module      : status_accum
// Description : One status channel accumulator; the mode is fixed at build
//               time (LIVE, STICKY, MAX or saturating COUNT).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module status_accum
    import opb_status_bank_pkg::*;
#(
    parameter int       STATUS_W = 32,
    parameter ch_mode_e MODE     = MODE_STICKY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic                i_clear,
    input  logic [STATUS_W-1:0] i_data,
    output logic [STATUS_W-1:0] o_acc
);

    logic [STATUS_W-1:0] r_acc_q;
    logic [STATUS_W-1:0] w_acc_d;
    logic [STATUS_W-1:0] w_base;

    always_comb begin
        // A clear in the same cycle as a sample acts first, so the sample survives.
        w_base  = i_clear ? '0 : r_acc_q;
        w_acc_d = w_base;
        if (i_valid) begin
            case (MODE)
                MODE_LIVE:   w_acc_d = i_data;
                MODE_STICKY: w_acc_d = w_base | i_data;
                MODE_MAX:    w_acc_d = (w_base > i_data) ? w_base : i_data;
                MODE_COUNT:  w_acc_d = (&w_base) ? w_base : w_base + STATUS_W'(1);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_q <= '0;
        end else begin
            r_acc_q <= w_acc_d;
        end
    end

    assign o_acc = r_acc_q;

endmodule

`default_nettype wire

// File: rtl/opb_status_bank.sv
// ============================================================================
// Module      : opb_status_bank
// Description : OPB slave exposing C_NUM_CH user status accumulators through
//               snapshot shadows, with atomic snapshot-and-clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opb_status_bank
    import opb_status_bank_pkg::*;
#(
    parameter logic [31:0]            C_BASEADDR   = 32'h0108_0100,
    parameter logic [31:0]            C_HIGHADDR   = 32'h0108_01FF,
    parameter int                     C_OPB_AWIDTH = 32,
    parameter int                     C_OPB_DWIDTH = 32,
    parameter string                  C_FAMILY     = "virtex5",
    parameter int                     C_NUM_CH     = 8,
    parameter int                     C_STATUS_W   = 32,
    parameter logic [2*C_NUM_CH-1:0]  C_CH_MODE    = {C_NUM_CH{2'd1}}
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst,
    input  logic [0:31]                      OPB_ABus,
    input  logic [0:3]                       OPB_BE,
    input  logic [0:31]                      OPB_DBus,
    input  logic                             OPB_RNW,
    input  logic                             OPB_select,
    input  logic                             OPB_seqAddr,
    output logic [0:31]                      Sl_DBus,
    output logic                             Sl_xferAck,
    output logic                             Sl_errAck,
    output logic                             Sl_retry,
    output logic                             Sl_toutSup,
    input  logic [C_NUM_CH*C_STATUS_W-1:0]   user_data_in,
    input  logic [C_NUM_CH-1:0]              user_valid
);

    localparam int    c_unused_widths = C_OPB_AWIDTH + C_OPB_DWIDTH;
    localparam string c_unused_family = C_FAMILY;

    logic [31:0] w_addr;
    logic [31:0] w_off;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic        w_hit;

    logic        r_ack_q,       w_ack_d;
    logic [31:0] r_dbus_q,      w_dbus_d;
    logic        r_snap_req_q,  w_snap_req_d;
    logic        r_clear_all_q, w_clear_all_d;
    logic [C_NUM_CH-1:0] r_mask_q, w_mask_d;
    logic [15:0] r_snap_count_q, w_snap_count_d;

    logic [C_STATUS_W-1:0] r_shadow_q [C_NUM_CH];
    logic [C_STATUS_W-1:0] w_shadow_d [C_NUM_CH];
    logic [C_STATUS_W-1:0] w_acc      [C_NUM_CH];

    logic                w_snap;
    logic [C_NUM_CH-1:0] w_clear;
    logic                w_unused;

    // Bit 0 of the big-endian OPB buses is the word MSB, so plain assignment aligns them.
    assign w_addr  = OPB_ABus;
    assign w_wdata = OPB_DBus;
    assign w_off   = w_addr - C_BASEADDR;
    assign w_hit   = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR) && !r_ack_q;

    always_comb begin
        w_rdata = '0;
        if (w_off == c_off_id) begin
            w_rdata = id_word(C_NUM_CH, C_STATUS_W);
        end else if (w_off == c_off_snap_count) begin
            w_rdata = {16'h0000, r_snap_count_q};
        end
        for (int k = 0; k < C_NUM_CH; k++) begin
            if (w_off == ch_offset(k)) begin
                w_rdata = 32'(r_shadow_q[k]);
            end
        end
    end

    // Read data and write intent are captured at the hit; writes act in the ack cycle.
    always_comb begin
        w_ack_d       = w_hit;
        w_dbus_d      = '0;
        w_snap_req_d  = 1'b0;
        w_clear_all_d = 1'b0;
        w_mask_d      = '0;
        if (w_hit) begin
            if (OPB_RNW) begin
                w_dbus_d = w_rdata;
            end else begin
                if (w_off == c_off_ctrl) begin
                    w_snap_req_d  = w_wdata[c_ctrl_snap_bit];
                    w_clear_all_d = w_wdata[c_ctrl_clear_all_bit];
                end
                if (w_off == c_off_clear_mask) begin
                    w_mask_d = w_wdata[C_NUM_CH-1:0];
                end
            end
        end
    end

    assign w_snap  = r_ack_q & r_snap_req_q;
    assign w_clear = {C_NUM_CH{r_ack_q & r_clear_all_q}} | (r_ack_q ? r_mask_q : '0);

    // Shadows take the registered accumulators, i.e. the value before this cycle's clear/sample.
    always_comb begin
        w_snap_count_d = r_snap_count_q;
        for (int k = 0; k < C_NUM_CH; k++) begin
            w_shadow_d[k] = r_shadow_q[k];
        end
        if (w_snap) begin
            w_snap_count_d = r_snap_count_q + 16'd1;
            for (int k = 0; k < C_NUM_CH; k++) begin
                w_shadow_d[k] = w_acc[k];
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_ack_q        <= 1'b0;
            r_dbus_q       <= '0;
            r_snap_req_q   <= 1'b0;
            r_clear_all_q  <= 1'b0;
            r_mask_q       <= '0;
            r_snap_count_q <= '0;
            for (int k = 0; k < C_NUM_CH; k++) begin
                r_shadow_q[k] <= '0;
            end
        end else begin
            r_ack_q        <= w_ack_d;
            r_dbus_q       <= w_dbus_d;
            r_snap_req_q   <= w_snap_req_d;
            r_clear_all_q  <= w_clear_all_d;
            r_mask_q       <= w_mask_d;
            r_snap_count_q <= w_snap_count_d;
            for (int k = 0; k < C_NUM_CH; k++) begin
                r_shadow_q[k] <= w_shadow_d[k];
            end
        end
    end

    for (genvar k = 0; k < C_NUM_CH; k++) begin : g_ch
        status_accum #(
            .STATUS_W (C_STATUS_W),
            .MODE     (ch_mode_e'(C_CH_MODE[2*k +: 2]))
        ) u_accum (
            .clk     (OPB_Clk),
            .rst     (OPB_Rst),
            .i_valid (user_valid[k]),
            .i_clear (w_clear[k]),
            .i_data  (user_data_in[k*C_STATUS_W +: C_STATUS_W]),
            .o_acc   (w_acc[k])
        );
    end

    assign Sl_DBus    = r_dbus_q;
    assign Sl_xferAck = r_ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign w_unused = ^{OPB_BE, OPB_seqAddr, w_wdata};

endmodule

`default_nettype wire
